// File: rtl/test_ram_pkg.sv
// Shared types and constants for the self-checking RAM exerciser.
// Holds the sequencer state encoding and the expected-data pattern function.
package test_ram_pkg;

   localparam int unsigned DefAddrW = 3;
   localparam int unsigned DefDataW = 6;
   localparam logic [DefDataW-1:0] DefPattern = 6'h2A;

   typedef enum logic {
      StWrite,
      StRead
   } state_e;

   // Expected word for an address: zero-extended address XOR seed; caller truncates.
   function automatic logic [31:0] exp_data(input logic [31:0] addr, input logic [31:0] pattern);
      return addr ^ pattern;
   endfunction

endpackage

// File: rtl/sp_ram_sync.sv
// Single-port synchronous RAM with a registered read port.
// The array itself is never reset; only the read register clears on reset.
module sp_ram_sync #(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned DATA_W = 6
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   localparam int unsigned Depth = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [Depth];
   logic [DATA_W-1:0] rdata_d, rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re_i) begin
         rdata_d = mem[addr_i];
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/test_ram.sv
// RAM exerciser: fills the RAM with a known pattern, then reads it back forever,
// checking every word and raising sticky done/err flags.
module test_ram
   import test_ram_pkg::*;
#(
   parameter int unsigned          ADDR_W  = DefAddrW,
   parameter int unsigned          DATA_W  = DefDataW,
   parameter logic [DATA_W-1:0]    PATTERN = DefPattern
) (
   input  logic              sysclk,
   input  logic              reset,
   input  logic              inj_fault,
   output logic [DATA_W-1:0] DC_X,
   output logic              done,
   output logic              err
);

   state_e            state_d, state_q;
   logic [ADDR_W-1:0] addr_d, addr_q;
   logic [ADDR_W-1:0] chk_addr_d, chk_addr_q;
   logic              rd_valid_d, rd_valid_q;
   logic              done_d, done_q;
   logic              err_d, err_q;
   logic              ram_we, ram_re;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] exp_wr, exp_chk;

   assign exp_wr  = DATA_W'(exp_data(32'(addr_q), 32'(PATTERN)));
   assign exp_chk = DATA_W'(exp_data(32'(chk_addr_q), 32'(PATTERN)));
   assign ram_wdata = exp_wr ^ DATA_W'(inj_fault);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q + ADDR_W'(1);
      chk_addr_d = chk_addr_q;
      rd_valid_d = rd_valid_q;
      done_d     = done_q;
      err_d      = err_q;
      ram_we     = 1'b0;
      ram_re     = 1'b0;
      unique case (state_q)
         StWrite: begin
            ram_we = 1'b1;
            // Address wraps to 0 naturally as the last word is written.
            if (addr_q == {ADDR_W{1'b1}}) begin
               state_d = StRead;
            end
         end
         StRead: begin
            ram_re     = 1'b1;
            chk_addr_d = addr_q;
            rd_valid_d = 1'b1;
         end
         default: state_d = StWrite;
      endcase
      // DC_X holds the word fetched on the previous edge for chk_addr_q.
      if (rd_valid_q) begin
         if (DC_X != exp_chk) begin
            err_d = 1'b1;
         end
         if (chk_addr_q == {ADDR_W{1'b1}}) begin
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge sysclk or posedge reset) begin
      if (reset) begin
         state_q    <= StWrite;
         addr_q     <= '0;
         chk_addr_q <= '0;
         rd_valid_q <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         chk_addr_q <= chk_addr_d;
         rd_valid_q <= rd_valid_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   sp_ram_sync #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_ram (
      .clk_i  (sysclk),
      .rst_i  (reset),
      .we_i   (ram_we),
      .re_i   (ram_re),
      .addr_i (addr_q),
      .wdata_i(ram_wdata),
      .rdata_o(DC_X)
   );

   assign done = done_q;
   assign err  = err_q;

endmodule

// File: tb/tb_test_ram.sv
// Self-checking bench for test_ram: scoreboard of written words replayed cyclically
// against DC_X, plus done/err timing, fault injection and async reset checks.
module tb_test_ram;

   logic       sysclk = 1'b0;
   logic       reset = 1'b1;
   logic       inj_fault = 1'b0;
   logic [5:0] DC_X;
   logic       done;
   logic       err;

   int total = 0;
   int bad = 0;

   logic [5:0] sb [$];
   logic [5:0] pat [8] = '{6'h2A, 6'h2B, 6'h28, 6'h29, 6'h2E, 6'h2F, 6'h2C, 6'h2D};

   always #10 sysclk = ~sysclk;

   test_ram dut (
      .sysclk   (sysclk),
      .reset    (reset),
      .inj_fault(inj_fault),
      .DC_X     (DC_X),
      .done     (done),
      .err      (err)
   );

   // Hold reset three cycles, release mid-cycle so the next rising edge is edge 0.
   task automatic start_run();
      reset = 1'b1;
      inj_fault = 1'b0;
      repeat (3) @(posedge sysclk);
      @(negedge sysclk);
      reset = 1'b0;
      sb.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge sysclk);
      #1;
      total++;
      if (DC_X !== 6'h00) begin bad++; $display("FAIL reset_dcx got=%h want=00", DC_X); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err); end
   endtask

   // Clean run: write phase, cyclic read-back, done timing, wrap-around.
   task automatic test_normal();
      logic [5:0] e;
      logic       want_done;
      start_run();
      for (int k = 0; k < 25; k++) begin
         if (k < 8) sb.push_back(pat[k]);
         @(posedge sysclk);
         #1;
         total++;
         if (k < 8) begin
            if (DC_X !== 6'h00) begin
               bad++; $display("FAIL write_dcx edge=%0d got=%h want=00", k, DC_X);
            end
         end else begin
            e = sb.pop_front();
            sb.push_back(e);
            if (DC_X !== e) begin
               bad++; $display("FAIL read_dcx edge=%0d got=%h want=%h", k, DC_X, e);
            end
         end
         want_done = (k >= 16);
         total++;
         if (done !== want_done) begin
            bad++; $display("FAIL done edge=%0d got=%b want=%b", k, done, want_done);
         end
         total++;
         if (err !== 1'b0) begin
            bad++; $display("FAIL clean_err edge=%0d got=%b want=0", k, err);
         end
         if (k == 16) begin
            total++;
            if (DC_X !== 6'h2A) begin
               bad++; $display("FAIL wrap_dcx edge=%0d got=%h want=2a", k, DC_X);
            end
         end
      end
   endtask

   // Corrupt bit 0 of address 3 during the write pass; err must rise and stick.
   task automatic test_fault();
      logic [5:0] e;
      logic       want_err;
      start_run();
      for (int k = 0; k < 30; k++) begin
         inj_fault = (k == 3);
         if (k < 8) sb.push_back((k == 3) ? (pat[k] ^ 6'h01) : pat[k]);
         @(posedge sysclk);
         #1;
         inj_fault = 1'b0;
         if (k >= 8) begin
            e = sb.pop_front();
            sb.push_back(e);
            total++;
            if (DC_X !== e) begin
               bad++; $display("FAIL fault_dcx edge=%0d got=%h want=%h", k, DC_X, e);
            end
         end
         if (k == 11) begin
            total++;
            if (DC_X !== 6'h28) begin
               bad++; $display("FAIL fault_word3 edge=%0d got=%h want=28", k, DC_X);
            end
         end
         want_err = (k >= 12);
         total++;
         if (err !== want_err) begin
            bad++; $display("FAIL fault_err edge=%0d got=%b want=%b", k, err, want_err);
         end
      end
   endtask

   // Reset asserted between edges mid-READ clears outputs at once; sequence restarts.
   task automatic test_async_reset();
      logic [5:0] e;
      logic       want_done;
      start_run();
      for (int k = 0; k < 20; k++) begin
         inj_fault = (k == 0);
         @(posedge sysclk);
         #1;
         inj_fault = 1'b0;
      end
      total++;
      if (done !== 1'b1 || err !== 1'b1) begin
         bad++; $display("FAIL pre_reset_flags got=%b%b want=11", done, err);
      end
      #4;
      reset = 1'b1;
      #1;
      total++;
      if (DC_X !== 6'h00) begin bad++; $display("FAIL async_dcx got=%h want=00", DC_X); end
      total++;
      if (done !== 1'b0) begin bad++; $display("FAIL async_done got=%b want=0", done); end
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL async_err got=%b want=0", err); end
      repeat (2) @(posedge sysclk);
      @(negedge sysclk);
      reset = 1'b0;
      sb.delete();
      for (int k = 0; k < 20; k++) begin
         if (k < 8) sb.push_back(pat[k]);
         @(posedge sysclk);
         #1;
         if (k >= 8) begin
            e = sb.pop_front();
            sb.push_back(e);
            total++;
            if (DC_X !== e) begin
               bad++; $display("FAIL restart_dcx edge=%0d got=%h want=%h", k, DC_X, e);
            end
         end
         want_done = (k >= 16);
         total++;
         if (done !== want_done || err !== 1'b0) begin
            bad++;
            $display("FAIL restart_flags edge=%0d got=%b%b want=%b0", k, done, err, want_done);
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_fault();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
